// File: rtl/keypad_pkg.sv
// Shared types for the 4x4 keypad scanner: FSM states, frame results, key width.
package keypad_pkg;

  localparam int unsigned KEY_W = 4;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESS_CHK   = 2'd1,
    HELD        = 2'd2,
    RELEASE_CHK = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    KEY   = 2'd1,
    MULTI = 2'd2
  } result_t;

  // Key code is row*4+col, i.e. row in the upper two bits.
  function automatic logic [KEY_W-1:0] key_code(input logic [1:0] row,
                                                input logic [1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/keypad_tick.sv
// Column-step strobe: one-clk pulse every SCAN_DIV clocks, stays in the clk domain.
module keypad_tick #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_tick
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == LAST);
  assign o_tick = w_last;

  // Free-running 0..SCAN_DIV-1 counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: drives columns, samples synced rows, debounces, rejects ghosts.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned DEBOUNCE_N = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       i_row,
  output logic [3:0]       o_col,
  output logic [KEY_W-1:0] o_key_code,
  output logic             o_key_valid,
  output logic             o_key_held
);

  localparam logic [3:0] DB_N = 4'(DEBOUNCE_N);

  logic             w_tick;
  logic [3:0]       r_row_s1;
  logic [3:0]       r_row_s2;
  logic [1:0]       r_col_idx;
  logic [1:0]       w_col_next;
  logic [3:0]       r_col;
  logic [1:0]       r_hit_cnt;
  logic [KEY_W-1:0] r_hit_code;

  logic [1:0]       w_smp_cnt;
  logic [1:0]       w_smp_row;
  logic [2:0]       w_sum;
  logic [1:0]       w_acc_cnt;
  logic [KEY_W-1:0] w_acc_code;
  logic             w_frame_end;
  result_t          w_res;
  logic             w_match;

  state_t           r_state;
  logic [KEY_W-1:0] r_cand;
  logic [3:0]       r_dcnt;
  logic [3:0]       w_dcnt_inc;
  logic [KEY_W-1:0] r_key_code;
  logic             r_key_valid;
  logic             r_key_held;

  keypad_tick #(
    .SCAN_DIV(SCAN_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .o_tick(w_tick)
  );

  assign w_col_next  = r_col_idx + 2'd1;
  assign w_frame_end = w_tick && (r_col_idx == 2'd3);

  // Count low rows in this column sample (saturating at 2) and pick the last one.
  always_comb begin
    w_smp_cnt = 2'd0;
    w_smp_row = 2'd0;
    for (int unsigned r = 0; r < 4; r++) begin
      if (!r_row_s2[r]) begin
        if (w_smp_cnt != 2'd2) w_smp_cnt = w_smp_cnt + 2'd1;
        w_smp_row = 2'(r);
      end
    end
    w_sum      = {1'b0, r_hit_cnt} + {1'b0, w_smp_cnt};
    w_acc_cnt  = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
    w_acc_code = (w_smp_cnt != 2'd0) ? key_code(w_smp_row, r_col_idx) : r_hit_code;
  end

  // Classify the frame including the column-3 sample taken this cycle.
  always_comb begin
    unique case (w_acc_cnt)
      2'd0:    w_res = NONE;
      2'd1:    w_res = KEY;
      default: w_res = MULTI;
    endcase
    w_match    = (w_res == KEY) && (w_acc_code == r_cand);
    w_dcnt_inc = r_dcnt + 4'd1;
  end

  // Row synchronizer, column drive and per-frame hit accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row_s1   <= '1;
      r_row_s2   <= '1;
      r_col_idx  <= '0;
      r_col      <= 4'b1110;
      r_hit_cnt  <= '0;
      r_hit_code <= '0;
    end else begin
      r_row_s1 <= i_row;
      r_row_s2 <= r_row_s1;
      if (w_tick) begin
        r_col_idx <= w_col_next;
        r_col     <= ~(4'b0001 << w_col_next);
        if (w_frame_end) begin
          r_hit_cnt  <= '0;
          r_hit_code <= '0;
        end else begin
          r_hit_cnt  <= w_acc_cnt;
          r_hit_code <= w_acc_code;
        end
      end
    end
  end

  // Debounce FSM with registered outputs; advances only on frame close.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cand      <= '0;
      r_dcnt      <= '0;
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      if (w_frame_end) begin
        unique case (r_state)
          IDLE: begin
            if (w_res == KEY) begin
              r_cand  <= w_acc_code;
              r_dcnt  <= 4'd1;
              r_state <= PRESS_CHK;
            end
          end
          PRESS_CHK: begin
            if (w_match) begin
              r_dcnt <= w_dcnt_inc;
              if (w_dcnt_inc == DB_N) begin
                r_state     <= HELD;
                r_key_code  <= r_cand;
                r_key_valid <= 1'b1;
                r_key_held  <= 1'b1;
              end
            end else if (w_res == KEY) begin
              r_cand <= w_acc_code;
              r_dcnt <= 4'd1;
            end else begin
              r_state <= IDLE;
            end
          end
          HELD: begin
            if (!w_match) begin
              r_state <= RELEASE_CHK;
              r_dcnt  <= 4'd1;
            end
          end
          RELEASE_CHK: begin
            if (w_match) begin
              r_state <= HELD;
            end else begin
              r_dcnt <= w_dcnt_inc;
              if (w_dcnt_inc == DB_N) begin
                r_state    <= IDLE;
                r_key_held <= 1'b0;
              end
            end
          end
        endcase
      end
    end
  end

  assign o_col       = r_col;
  assign o_key_code  = r_key_code;
  assign o_key_valid = r_key_valid;
  assign o_key_held  = r_key_held;

endmodule
